wb_stage_reg: RTL and testbench

- Parametrised MEM->WB pipeline register, successor to the single-channel stage register.
- Carries NCH independent write-back channels (inst, reg write enable, address, data) plus a per-channel valid bit from MEM to the register file.
- Honours the global stall vector and a new synchronous flush.
- Resolves same-cycle same-address write conflicts between channels at capture time.

---
 rtl/wb_stage_reg_pkg.sv | 33 +++
 rtl/wb_stage_reg_conflict_resolve.sv | 41 ++++
 rtl/wb_stage_reg.sv | 137 +++++++++++++
 tb/tb_wb_stage_reg.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg_pkg
// Shared constants and types for the MEM->WB stage register.
//   Stop / NoStop   : stall vector bit values (1 = stop)
//   ZeroWord        : all-zero data word
//   DEF_*           : default data / address / instruction widths
//   wb_ch_t         : one write-back channel record at default widths
//   popcnt4         : population count of up to four channel bits
// -----------------------------------------------------------------------------
package wb_stage_reg_pkg;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_INST_W = 32;

    localparam logic [DEF_DATA_W-1:0] ZeroWord = '0;

    typedef struct packed {
        logic                  valid;
        logic [DEF_INST_W-1:0] inst;
        logic                  we;
        logic [DEF_ADDR_W-1:0] waddr;
        logic [DEF_DATA_W-1:0] wdata;
    } wb_ch_t;

    function automatic logic [2:0] popcnt4(input logic [3:0] v);
        popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/wb_stage_reg_conflict_resolve.sv
// -----------------------------------------------------------------------------
// wb_conflict_resolve
// Combinational write-conflict resolver for NCH write-back channels.
// A channel only writes when both valid and we are set. When two writing
// channels target the same address, the younger (higher index) one wins and
// the older one's write enable is masked.
// Ports:
//   i_valid    [NCH]         per-channel valid
//   i_we       [NCH]         per-channel write enable
//   i_waddr    [NCH*ADDR_W]  per-channel destination address
//   o_we       [NCH]         resolved write enable
//   o_suppress [NCH]         1 where a valid write was masked by a younger one
// -----------------------------------------------------------------------------
module wb_conflict_resolve #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 5
) (
    input  logic [NCH-1:0]        i_valid,
    input  logic [NCH-1:0]        i_we,
    input  logic [NCH*ADDR_W-1:0] i_waddr,
    output logic [NCH-1:0]        o_we,
    output logic [NCH-1:0]        o_suppress
);

    logic [NCH-1:0] w_we_eff;

    always_comb begin
        w_we_eff   = i_we & i_valid;
        o_suppress = '0;
        for (int j = 0; j < NCH; j++) begin
            for (int k = j + 1; k < NCH; k++) begin
                if (w_we_eff[j] && w_we_eff[k] &&
                    (i_waddr[j*ADDR_W +: ADDR_W] == i_waddr[k*ADDR_W +: ADDR_W])) begin
                    o_suppress[j] = 1'b1;
                end
            end
        end
        o_we = w_we_eff & ~o_suppress;
    end

endmodule

// File: rtl/wb_stage_reg.sv
// -----------------------------------------------------------------------------
// wb_stage_reg
// MEM->WB pipeline register carrying NCH write-back channels to the register
// file. Honours the global stall vector and a synchronous flush, and resolves
// same-address write conflicts between channels at capture time.
// Optional feature macro: WB_STAGE_PERF_EN (adds retire/bubble/conflict
// counters; absent by default).
// Ports:
//   clk       clock, rising edge
//   rst       synchronous reset, active low
//   stall     stall vector, bit STAGE_IDX = this stage, STAGE_IDX+1 = downstream
//   flush     clear stage contents
//   valid_i / inst_i / we_i / waddr_i / wdata_i   per-channel MEM inputs
//   valid_o / inst_o / we_o / waddr_o / wdata_o   registered outputs
//   bubble_o  1 when the contents are an inserted bubble
//   retire_cnt_o / bubble_cnt_o / conflict_cnt_o  (WB_STAGE_PERF_EN only)
// -----------------------------------------------------------------------------
module wb_stage_reg
    import wb_stage_reg_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int INST_W    = DEF_INST_W,
    parameter int STALL_W   = 6,
    parameter int STAGE_IDX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [NCH-1:0]        valid_i,
    input  logic [NCH*INST_W-1:0] inst_i,
    input  logic [NCH-1:0]        we_i,
    input  logic [NCH*ADDR_W-1:0] waddr_i,
    input  logic [NCH*DATA_W-1:0] wdata_i,
    output logic [NCH-1:0]        valid_o,
    output logic [NCH*INST_W-1:0] inst_o,
    output logic [NCH-1:0]        we_o,
    output logic [NCH*ADDR_W-1:0] waddr_o,
    output logic [NCH*DATA_W-1:0] wdata_o,
    output logic                  bubble_o
`ifdef WB_STAGE_PERF_EN
    ,
    output logic [31:0]           retire_cnt_o,
    output logic [31:0]           bubble_cnt_o,
    output logic [15:0]           conflict_cnt_o
`endif
);

    logic                  r_bubble;
    logic [NCH-1:0]        r_valid;
    logic [NCH*INST_W-1:0] r_inst;
    logic [NCH-1:0]        r_we;
    logic [NCH*ADDR_W-1:0] r_waddr;
    logic [NCH*DATA_W-1:0] r_wdata;

    logic                  w_s_cur;
    logic                  w_s_nxt;
    logic                  w_clear;
    logic                  w_bubble_ins;
    logic                  w_load;
    logic [NCH-1:0]        w_we_res;
    logic [NCH-1:0]        w_suppress;

    assign w_s_cur = stall[STAGE_IDX];
    assign w_s_nxt = stall[STAGE_IDX+1];

    // Priority: reset/flush, then bubble insertion, then load; anything else holds.
    assign w_clear      = !rst || flush;
    assign w_bubble_ins = !w_clear && (w_s_cur == Stop) && (w_s_nxt == NoStop);
    assign w_load       = !w_clear && (w_s_cur == NoStop);

    wb_conflict_resolve #(
        .NCH    (NCH),
        .ADDR_W (ADDR_W)
    ) u_conflict (
        .i_valid    (valid_i),
        .i_we       (we_i),
        .i_waddr    (waddr_i),
        .o_we       (w_we_res),
        .o_suppress (w_suppress)
    );

    always_ff @(posedge clk) begin
        if (w_clear || w_bubble_ins) begin
            r_valid  <= '0;
            r_inst   <= '0;
            r_we     <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_bubble <= 1'b1;
        end else if (w_load) begin
            r_valid  <= valid_i;
            r_inst   <= inst_i;
            r_we     <= w_we_res;
            r_waddr  <= waddr_i;
            r_wdata  <= wdata_i;
            r_bubble <= 1'b0;
        end
    end

    assign valid_o  = r_valid;
    assign inst_o   = r_inst;
    assign we_o     = r_we;
    assign waddr_o  = r_waddr;
    assign wdata_o  = r_wdata;
    assign bubble_o = r_bubble;

`ifdef WB_STAGE_PERF_EN
    logic [31:0] r_retire_cnt;
    logic [31:0] r_bubble_cnt;
    logic [15:0] r_conflict_cnt;

    // Counters survive flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_retire_cnt   <= '0;
            r_bubble_cnt   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_load) begin
                r_retire_cnt   <= r_retire_cnt + 32'(popcnt4(4'(valid_i)));
                r_conflict_cnt <= r_conflict_cnt + 16'(popcnt4(4'(w_suppress)));
            end
            if (w_bubble_ins) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign retire_cnt_o   = r_retire_cnt;
    assign bubble_cnt_o   = r_bubble_cnt;
    assign conflict_cnt_o = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_stage_reg.sv
module tb_wb_stage_reg;
    import wb_stage_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [1:0]  valid_i;
    logic [63:0] inst_i;
    logic [1:0]  we_i;
    logic [9:0]  waddr_i;
    logic [63:0] wdata_i;
    logic [1:0]  valid_o;
    logic [63:0] inst_o;
    logic [1:0]  we_o;
    logic [9:0]  waddr_o;
    logic [63:0] wdata_o;
    logic        bubble_o;
`ifdef WB_STAGE_PERF_EN
    logic [31:0] retire_cnt_o;
    logic [31:0] bubble_cnt_o;
    logic [15:0] conflict_cnt_o;
`endif

    always #5 clk = ~clk;

    wb_stage_reg #(
        .NCH(2), .DATA_W(32), .ADDR_W(5), .INST_W(32), .STALL_W(6), .STAGE_IDX(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall    (stall),
        .flush    (flush),
        .valid_i  (valid_i),
        .inst_i   (inst_i),
        .we_i     (we_i),
        .waddr_i  (waddr_i),
        .wdata_i  (wdata_i),
        .valid_o  (valid_o),
        .inst_o   (inst_o),
        .we_o     (we_o),
        .waddr_o  (waddr_o),
        .wdata_o  (wdata_o),
        .bubble_o (bubble_o)
`ifdef WB_STAGE_PERF_EN
        ,
        .retire_cnt_o   (retire_cnt_o),
        .bubble_cnt_o   (bubble_cnt_o),
        .conflict_cnt_o (conflict_cnt_o)
`endif
    );

    typedef struct packed {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [9:0]  waddr;
        logic [63:0] wdata;
        logic [63:0] inst;
        logic        bubble;
    } obs_t;

    typedef struct {
        int    due;
        obs_t  exp;
        string name;
    } sb_t;

    sb_t  sb_q[$];
    obs_t last_exp;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    localparam int K_ZERO = 0;  // stage cleared
    localparam int K_LOAD = 1;  // this vector's inputs captured
    localparam int K_HOLD = 2;  // previous contents kept

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares DUT outputs against the expectation due this cycle.
    always @(negedge clk) begin
        obs_t act;
        sb_t  e;
        act = {valid_o, we_o, waddr_o, wdata_o, inst_o, bubble_o};
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            n_vec++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got valid=%b we=%b waddr=%h wdata=%h inst=%h bubble=%b, need valid=%b we=%b waddr=%h wdata=%h inst=%h bubble=%b",
                         e.name, act.valid, act.we, act.waddr, act.wdata, act.inst, act.bubble,
                         e.exp.valid, e.exp.we, e.exp.waddr, e.exp.wdata, e.exp.inst, e.exp.bubble);
            end
        end
    end

    task automatic vec(input string nm, input logic r, input logic [5:0] st, input logic fl,
                       input logic [1:0] v, input logic [1:0] w,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input int kind, input logic [1:0] ev, input logic [1:0] ew, input logic eb);
        sb_t e;
        @(posedge clk);
        #1;
        rst     = r;
        stall   = st;
        flush   = fl;
        valid_i = v;
        we_i    = w;
        waddr_i = {a1, a0};
        wdata_i = {d1, d0};
        inst_i  = {i1, i0};
        case (kind)
            K_ZERO: begin
                e.exp       = '0;
                e.exp.wdata = {ZeroWord, ZeroWord};
            end
            K_LOAD: begin
                e.exp.waddr = {a1, a0};
                e.exp.wdata = {d1, d0};
                e.exp.inst  = {i1, i0};
            end
            default: e.exp = last_exp;
        endcase
        e.exp.valid  = ev;
        e.exp.we     = ew;
        e.exp.bubble = eb;
        last_exp = e.exp;
        e.due    = cyc + 1;
        e.name   = nm;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (sb_q.size() > 0) begin
            $display("FAIL drain_timeout: got %0d pending, need 0", sb_q.size());
            n_err += sb_q.size();
            sb_q.delete();
        end
    endtask

    initial begin
        rst = 1'b0; stall = '0; flush = 1'b0; valid_i = '0; we_i = '0;
        waddr_i = '0; wdata_i = '0; inst_i = '0;
        last_exp = '0;

        //  name              rst stall      fl  v      w      a0  a1  d0            d1            i0            i1            kind    ev     ew     eb
        vec("reset_a",        0, 6'b000000, 0, 2'b11, 2'b11, 9,  10, 32'hAAAA5555, 32'h00001234, 32'h1,        32'h2,        K_ZERO, 2'b00, 2'b00, 1);
        vec("reset_b",        0, 6'b110000, 0, 2'b10, 2'b01, 17, 3,  32'h0BADF00D, 32'hCAFEBABE, 32'h3,        32'h4,        K_ZERO, 2'b00, 2'b00, 1);
        vec("load_deadbeef",  1, 6'b000000, 0, 2'b01, 2'b01, 5,  2,  32'hDEADBEEF, 32'h00000055, 32'h00500093, 32'h00200113, K_LOAD, 2'b01, 2'b01, 0);
        vec("bubble",         1, 6'b010000, 0, 2'b11, 2'b11, 1,  2,  32'h3,        32'h4,        32'h5,        32'h6,        K_ZERO, 2'b00, 2'b00, 1);
        vec("load_7",         1, 6'b000000, 0, 2'b11, 2'b11, 7,  8,  32'h12,       32'h34,       32'h700,      32'h800,      K_LOAD, 2'b11, 2'b11, 0);
        vec("hold_1",         1, 6'b110000, 0, 2'b11, 2'b11, 1,  1,  32'hFF,       32'hEE,       32'h0,        32'h0,        K_HOLD, 2'b11, 2'b11, 0);
        vec("hold_2",         1, 6'b110000, 0, 2'b00, 2'b00, 2,  2,  32'hF0,       32'hE0,       32'h9,        32'h9,        K_HOLD, 2'b11, 2'b11, 0);
        vec("hold_3",         1, 6'b111111, 0, 2'b01, 2'b10, 3,  3,  32'h1,        32'h2,        32'h9,        32'h9,        K_HOLD, 2'b11, 2'b11, 0);
        vec("conflict_same",  1, 6'b000000, 0, 2'b11, 2'b11, 3,  3,  32'h1,        32'h2,        32'h31,       32'h32,       K_LOAD, 2'b11, 2'b10, 0);
        vec("conflict_diff",  1, 6'b000000, 0, 2'b11, 2'b11, 3,  4,  32'h1,        32'h2,        32'h41,       32'h42,       K_LOAD, 2'b11, 2'b11, 0);
        vec("invalid_ch1",    1, 6'b000000, 0, 2'b01, 2'b11, 6,  9,  32'h66,       32'h99,       32'h61,       32'h62,       K_LOAD, 2'b01, 2'b01, 0);
        vec("invalid_same",   1, 6'b000000, 0, 2'b10, 2'b11, 7,  7,  32'h70,       32'h71,       32'h71,       32'h72,       K_LOAD, 2'b10, 2'b10, 0);
        vec("other_stall",    1, 6'b001111, 0, 2'b10, 2'b10, 11, 12, 32'hA5,       32'h5A,       32'hB1,       32'hB2,       K_LOAD, 2'b10, 2'b10, 0);
        vec("nxt_only",       1, 6'b100000, 0, 2'b11, 2'b11, 10, 20, 32'hA,        32'hB,        32'hC1,       32'hC2,       K_LOAD, 2'b11, 2'b11, 0);
        vec("hold_pre_flush", 1, 6'b110000, 0, 2'b00, 2'b00, 0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        K_HOLD, 2'b11, 2'b11, 0);
        vec("flush_in_stall", 1, 6'b110000, 1, 2'b11, 2'b11, 1,  2,  32'h1,        32'h2,        32'h3,        32'h4,        K_ZERO, 2'b00, 2'b00, 1);
        vec("hold_flushed",   1, 6'b110000, 0, 2'b11, 2'b11, 1,  2,  32'h1,        32'h2,        32'h3,        32'h4,        K_HOLD, 2'b00, 2'b00, 1);
        vec("flush_vs_load",  1, 6'b000000, 1, 2'b11, 2'b11, 1,  2,  32'h1,        32'h2,        32'h3,        32'h4,        K_ZERO, 2'b00, 2'b00, 1);
        vec("addr0_write",    1, 6'b000000, 0, 2'b11, 2'b01, 0,  0,  32'h77,       32'h88,       32'hD1,       32'hD2,       K_LOAD, 2'b11, 2'b01, 0);
        vec("rst_mid_stall",  0, 6'b110000, 0, 2'b11, 2'b11, 4,  5,  32'h4,        32'h5,        32'h6,        32'h7,        K_ZERO, 2'b00, 2'b00, 1);
        vec("stall_after_rst",1, 6'b110000, 0, 2'b11, 2'b11, 4,  5,  32'h4,        32'h5,        32'h6,        32'h7,        K_HOLD, 2'b00, 2'b00, 1);
        vec("load_addr31",    1, 6'b000000, 0, 2'b10, 2'b10, 0,  31, 32'h0,        32'hFFFFFFFF, 32'h0,        32'hE2,       K_LOAD, 2'b10, 2'b10, 0);
        vec("idle_hold",      1, 6'b110000, 0, 2'b00, 2'b00, 0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        K_HOLD, 2'b10, 2'b10, 0);
        drain();

`ifdef WB_STAGE_PERF_EN
        vec("perf_reset",     0, 6'b000000, 0, 2'b00, 2'b00, 0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        K_ZERO, 2'b00, 2'b00, 1);
        vec("perf_conflict",  1, 6'b000000, 0, 2'b11, 2'b11, 4,  4,  32'h10,       32'h20,       32'h1,        32'h2,        K_LOAD, 2'b11, 2'b10, 0);
        for (int i = 1; i < 10; i++) begin
            vec("perf_load",  1, 6'b000000, 0, 2'b11, 2'b11, 1,  2,  32'(i),       32'(i + 100), 32'(i),       32'(i),       K_LOAD, 2'b11, 2'b11, 0);
        end
        for (int i = 0; i < 3; i++) begin
            vec("perf_bubble",1, 6'b010000, 0, 2'b11, 2'b11, 1,  2,  32'h1,        32'h2,        32'h3,        32'h4,        K_ZERO, 2'b00, 2'b00, 1);
        end
        vec("perf_flush",     1, 6'b110000, 1, 2'b11, 2'b11, 1,  2,  32'h1,        32'h2,        32'h3,        32'h4,        K_ZERO, 2'b00, 2'b00, 1);
        vec("perf_idle",      1, 6'b110000, 0, 2'b00, 2'b00, 0,  0,  32'h0,        32'h0,        32'h0,        32'h0,        K_HOLD, 2'b00, 2'b00, 1);
        drain();
        @(negedge clk);
        n_vec++;
        if (retire_cnt_o !== 32'd20) begin
            n_err++;
            $display("FAIL retire_cnt: got %0d, need 20", retire_cnt_o);
        end
        n_vec++;
        if (bubble_cnt_o !== 32'd3) begin
            n_err++;
            $display("FAIL bubble_cnt: got %0d, need 3", bubble_cnt_o);
        end
        n_vec++;
        if (conflict_cnt_o !== 16'd1) begin
            n_err++;
            $display("FAIL conflict_cnt: got %0d, need 1", conflict_cnt_o);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
